// File: rtl/sa_pkg.sv
// Shared widths, FSM state encoding and result arithmetic for the SA job sequencer.
package sa_pkg;

    localparam int TW = 10;
    localparam int XW = 8;
    localparam int YW = 10;
    localparam int EW = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

    // Signed distance of the solver result from its target, one extra bit for the sign.
    function automatic logic [EW-1:0] calc_err(input logic [YW-1:0] y, input logic [TW-1:0] t);
        calc_err = {1'b0, y} - {1'b0, t};
    endfunction

endpackage

// File: rtl/sa_job_fifo.sv
// Job target FIFO: power-of-two depth, write ignored while full, head visible on rdata.
module sa_job_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (count_r == DEPTH_C);
    assign empty  = (count_r == {(AW + 1){1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign rdata  = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sa_job_seq.sv
// Sequences queued targets through an external SA solver with a watchdog,
// holding each result until the consumer takes it.
module sa_job_seq
    import sa_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [TW-1:0] in_target,
    output logic          sa_start,
    output logic [TW-1:0] sa_target,
    input  logic          sa_done,
    input  logic [XW-1:0] sa_x,
    input  logic [YW-1:0] sa_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [TW-1:0] res_target,
    output logic [XW-1:0] res_x,
    output logic [YW-1:0] res_y,
    output logic [EW-1:0] res_err,
    output logic          res_timeout,
    output logic          busy
);

    localparam int WW = $clog2(TIMEOUT + 1);
    // Abort on the edge where the count would reach TIMEOUT, so a done rise up to
    // TIMEOUT cycles after sa_start is still accepted.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    seq_state_t    state_r;
    logic [WW-1:0] wd_r;
    logic          done_q_r;
    logic          sa_start_r;
    logic [TW-1:0] sa_target_r;
    logic          res_valid_r;
    logic          res_timeout_r;
    logic [TW-1:0] res_target_r;
    logic [XW-1:0] res_x_r;
    logic [YW-1:0] res_y_r;
    logic [EW-1:0] res_err_r;

    logic [TW-1:0] fifo_rdata_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          done_rise_s;

    assign push_s      = in_valid && !fifo_full_s;
    assign pop_s       = (state_r == ST_IDLE) && !fifo_empty_s && !res_valid_r;
    assign done_rise_s = sa_done && !done_q_r;

    sa_job_fifo #(
        .DEPTH (DEPTH),
        .DW    (TW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_target),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Job FSM, watchdog, done-edge detector and result register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            wd_r          <= {WW{1'b0}};
            done_q_r      <= 1'b0;
            sa_start_r    <= 1'b0;
            sa_target_r   <= {TW{1'b0}};
            res_valid_r   <= 1'b0;
            res_timeout_r <= 1'b0;
            res_target_r  <= {TW{1'b0}};
            res_x_r       <= {XW{1'b0}};
            res_y_r       <= {YW{1'b0}};
            res_err_r     <= {EW{1'b0}};
        end else begin
            done_q_r <= sa_done;
            if (res_valid_r && res_ready) begin
                res_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r     <= ST_START;
                        sa_start_r  <= 1'b1;
                        sa_target_r <= fifo_rdata_s;
                    end
                end
                ST_START: begin
                    state_r    <= ST_WAIT;
                    sa_start_r <= 1'b0;
                    wd_r       <= {WW{1'b0}};
                end
                ST_WAIT: begin
                    if (done_rise_s) begin
                        res_target_r  <= sa_target_r;
                        res_x_r       <= sa_x;
                        res_y_r       <= sa_y;
                        res_err_r     <= calc_err(sa_y, sa_target_r);
                        res_timeout_r <= 1'b0;
                        res_valid_r   <= 1'b1;
                        state_r       <= ST_DRAIN;
                    end else if (wd_r == WD_LAST) begin
                        res_target_r  <= sa_target_r;
                        res_x_r       <= {XW{1'b0}};
                        res_y_r       <= {YW{1'b0}};
                        res_err_r     <= {EW{1'b0}};
                        res_timeout_r <= 1'b1;
                        res_valid_r   <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        wd_r <= wd_r + {{(WW - 1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAIN: begin
                    if (!sa_done) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sa_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = !fifo_full_s;
    assign busy        = (state_r != ST_IDLE);
    assign sa_start    = sa_start_r;
    assign sa_target   = sa_target_r;
    assign res_valid   = res_valid_r;
    assign res_timeout = res_timeout_r;
    assign res_target  = res_target_r;
    assign res_x       = res_x_r;
    assign res_y       = res_y_r;
    assign res_err     = res_err_r;

endmodule
